// File: rtl/bcd_seq_ctrl.sv
// Sequential multi-digit BCD adder: one 2-digit BCD_Adder is time-shared across
// NUM_BYTES slices, LSB slice first. Optional macro BCD_CHECK_EN adds digit validation.
module BCD_Adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       c
);
  logic [4:0] lo_raw_s;
  logic [4:0] hi_raw_s;
  logic       lo_c_s;

  // Two decimal digits with +6 correction on each nibble
  always_comb begin
    lo_raw_s = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0000, Cin};
    lo_c_s   = (lo_raw_s > 5'd9);
    hi_raw_s = {1'b0, A[7:4]} + {1'b0, B[7:4]} + {4'b0000, lo_c_s};
    c        = (hi_raw_s > 5'd9);
    if (lo_c_s) begin
      S[3:0] = lo_raw_s[3:0] + 4'd6;
    end else begin
      S[3:0] = lo_raw_s[3:0];
    end
    if (c) begin
      S[7:4] = hi_raw_s[3:0] + 4'd6;
    end else begin
      S[7:4] = hi_raw_s[3:0];
    end
  end
endmodule

module bcd_seq_ctrl #(
  parameter int NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  input  logic                   cin,
  output logic                   ready,
  output logic [8*NUM_BYTES-1:0] sum,
  output logic                   cout,
  output logic                   done,
  output logic                   err
);
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_r;
  logic [8*NUM_BYTES-1:0] a_r;
  logic [8*NUM_BYTES-1:0] b_r;
  logic                   cin_r;
  logic                   carry_r;
  logic [IDX_W-1:0]       idx_r;
  logic [7:0]             slice_a_s;
  logic [7:0]             slice_b_s;
  logic                   slice_cin_s;
  logic [7:0]             add_s;
  logic                   add_c_s;

`ifdef BCD_CHECK_EN
  logic err_r;
  assign err = err_r;

  function automatic logic has_bad_digit(input logic [8*NUM_BYTES-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int n = 0; n < 2*NUM_BYTES; n++) begin
      if (v[4*n +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction
`else
  assign err = 1'b0;
`endif

  // Slice selection for the shared adder
  always_comb begin
    slice_a_s = a_r[{idx_r, 3'b000} +: 8];
    slice_b_s = b_r[{idx_r, 3'b000} +: 8];
    if (idx_r == '0) begin
      slice_cin_s = cin_r;
    end else begin
      slice_cin_s = carry_r;
    end
  end

  BCD_Adder u_adder (
    .A   (slice_a_s),
    .B   (slice_b_s),
    .Cin (slice_cin_s),
    .S   (add_s),
    .c   (add_c_s)
  );

  // Controller FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      cin_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
`ifdef BCD_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            cin_r   <= cin;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ready   <= 1'b0;
`ifdef BCD_CHECK_EN
            // Invalid digits bypass the adder entirely
            if (has_bad_digit(a) || has_bad_digit(b)) begin
              err_r   <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              err_r   <= 1'b0;
              state_r <= ADD;
            end
`else
            state_r <= ADD;
`endif
          end else begin
            ready <= 1'b1;
          end
        end
        ADD: begin
          sum[{idx_r, 3'b000} +: 8] <= add_s;
          carry_r <= add_c_s;
          if (idx_r == LAST_IDX) begin
            cout    <= add_c_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 2, meaning the number of 2-digit BCD slices per operand (4 digits by default).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only when ready=1.
REQ-005 SHALL have port a  input  8*NUM_BYTES  packed BCD operand A.
REQ-006 SHALL have port b  input  8*NUM_BYTES  packed BCD operand B.
REQ-007 SHALL have port cin  input  1  initial carry-in.
REQ-008 SHALL have port ready  output  1  high in IDLE; the controller accepts start.
REQ-009 SHALL have port sum  output  8*NUM_BYTES  packed BCD result.
REQ-010 SHALL have port cout  output  1  final decimal carry-out.
REQ-011 SHALL have port done  output  1  one-cycle pulse when sum/cout are valid.
REQ-012 SHALL have port err  output  1  invalid-digit flag; tied 0 when BCD_CHECK_EN is undefined.

Function
REQ-013 SHALL instantiate exactly one BCD_Adder (A[7:0], B[7:0], Cin, S[7:0], c) and time-share it across all slices.
REQ-014 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-015 In IDLE, start=1 SHALL latch a, b and cin into internal registers, clear the slice index to 0 and go to ADD on the next edge.
REQ-016 In ADD, slice i (bits 8i+7:8i, least-significant slice first) SHALL be applied to the adder once per cycle.
REQ-017 In ADD, the adder Cin SHALL be the latched cin for slice 0 and the registered carry of slice i-1 otherwise.
REQ-018 In ADD, the adder S SHALL be written into sum bits 8i+7:8i, and c SHALL be registered as the chain carry.
REQ-019 After slice NUM_BYTES-1, the FSM SHALL load cout with the final carry and go to DONE.
REQ-020 Slice index wrap is not permitted: the index SHALL count 0..NUM_BYTES-1 only.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 Latency from the start-accept edge to the done=1 cycle SHALL be NUM_BYTES+1 cycles; sustained throughput SHALL be one operation per NUM_BYTES+2 cycles.
REQ-023 ready SHALL be 1 only in IDLE.
REQ-024 start while ready=0 SHALL be ignored, with no queueing.
REQ-025 Changes on a, b or cin after acceptance SHALL NOT affect the operation in flight.
REQ-026 sum, cout and err SHALL hold their values from DONE until the next accepted start.
REQ-027 On an accepted start, sum and cout SHALL clear to 0.
REQ-028 start held high continuously SHALL launch a new operation on every IDLE visit.

Reset
REQ-029 rst_n=0 SHALL immediately force the FSM to IDLE, asynchronously, including mid-ADD.
REQ-030 While rst_n=0, outputs SHALL be: sum=0, cout=0, done=0, err=0, ready=1.
REQ-031 While rst_n=0, all internal operand, carry and index registers SHALL be 0.
REQ-032 After rst_n deasserts, start SHALL be accepted on the first rising edge.
REQ-033 An operation interrupted by reset SHALL produce no done pulse.

Configuration
REQ-034 With macro BCD_CHECK_EN defined, the controller SHALL check every latched nibble of a and b in the start-accept cycle.
REQ-035 With BCD_CHECK_EN defined and any nibble >9, the FSM SHALL skip ADD and go directly to DONE, with err=1, sum=0 and cout=0 (latency 1 cycle).
REQ-036 With BCD_CHECK_EN undefined, err SHALL be constant 0, no check logic SHALL exist, and invalid digits SHALL pass through the adder unchecked.

Verification (NUM_BYTES=2)
REQ-037 Bench SHALL drive a=0x0058, b=0x0049, cin=0, start pulse -> done exactly 3 cycles after accept, with sum=0x0107, cout=0.
REQ-038 Bench SHALL drive a=0x9999, b=0x9999, cin=0 -> sum=0x9998, cout=1; then a=0x0026, b=0x0015, cin=1 -> sum=0x0042, cout=0.
REQ-039 Bench SHALL pulse start again 1 cycle after accept, and change a to 0x1111 during ADD -> second start is ignored, a single done pulse occurs, and the result reflects the original operands.
REQ-040 Bench SHALL assert rst_n=0 mid-ADD during a=0x0505, b=0x0505 -> outputs are immediately at reset values with no done pulse; the next start then yields sum=0x1010.
REQ-041 Bench SHALL hold start=1 continuously with a=0x0001, b=0x0001 -> done pulses every 4 cycles, with sum=0x0002 each time.
REQ-042 Bench SHALL, with BCD_CHECK_EN defined, drive a=0x00A0, b=0x0001 -> done 1 cycle after accept, with err=1, sum=0x0000, cout=0.
